// File: rtl/param_word_capture.sv
// -----------------------------------------------------------------------------
// param_word_capture
//
// Purpose:
//   Captures parameter command words arriving from a 32-bit Nios II PIO output
//   register. The word is formatted as {index[7:0], value[23:0]}. Transient
//   and intermediate values are filtered out: a word is accepted only once it
//   has been stable for STABLE_CYCLES clocks. An accepted word is written into
//   a parameter register bank and offered downstream as a valid/ready beat.
//
// Parameters:
//   NUM_PARAMS    number of parameter slots in the bank (1..256)
//   STABLE_CYCLES consecutive unchanged samples required before commit (>=1)
//   CNT_W         width of the settle counter, must hold STABLE_CYCLES-1
//
// Ports:
//   clk           system clock, single domain
//   reset         asynchronous, active-high reset
//   in_word       command word from the PIO, [31:24] index, [23:0] value
//   upd_ready     downstream accepts the current update beat
//   upd_valid     update beat valid
//   upd_index     index of the committed parameter
//   upd_value     value of the committed parameter
//   param_flat    bank contents, slot i at [i*24 +: 24] (registered)
//   err_range     one-cycle pulse: stable word had index >= NUM_PARAMS
//   update_count  number of completed handshakes, wraps 0xFFFF -> 0
//
// Optional feature macro: PARAM_CAPTURE_SYNC_EN
//   When defined, in_word passes through a 2-stage register pipeline (reset
//   to 0) before change detection, for a PIO clocked from another domain.
//   The settle filter then guarantees multi-bit coherence. Commit latency
//   grows by exactly 2 cycles.
// -----------------------------------------------------------------------------
module param_word_capture #(
  parameter int NUM_PARAMS    = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in_word,
  input  logic                     upd_ready,
  output logic                     upd_valid,
  output logic [7:0]               upd_index,
  output logic [23:0]              upd_value,
  output logic [NUM_PARAMS*24-1:0] param_flat,
  output logic                     err_range,
  output logic [15:0]              update_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [8:0]       NUM_P9 = 9'(NUM_PARAMS);

  state_t                   state_q;
  state_t                   state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     pending_q;
  logic                     pending_d;
  logic [31:0]              prev_word;
  logic [31:0]              samp_word;
  logic                     change;
  logic                     in_range;
  logic                     commit_go;
  logic                     range_err_go;
  logic                     handshake;
  logic [15:0]              hs_count;
  logic [NUM_PARAMS*24-1:0] bank_q;

  // ---------------------------------------------------------------------------
  // Input sampling. With the sync option the word is re-registered twice so a
  // word launched from a foreign clock domain has settled before it is compared.
  // ---------------------------------------------------------------------------
`ifdef PARAM_CAPTURE_SYNC_EN
  logic [31:0] sync_q1;
  logic [31:0] sync_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 32'd0;
      sync_q2 <= 32'd0;
    end else begin
      sync_q1 <= in_word;
      sync_q2 <= sync_q1;
    end
  end

  assign samp_word = sync_q2;
`else
  assign samp_word = in_word;
`endif

  // prev_word resets to 0, so a word of 0 present at reset release is not a
  // change and cannot trigger a commit.
  assign change = (samp_word != prev_word);

  // Once settled, prev_word equals the stable word, so it is the commit source.
  // The 9-bit compare keeps NUM_PARAMS=256 from overflowing the index width.
  assign in_range = ({1'b0, prev_word[31:24]} < NUM_P9);

  // ---------------------------------------------------------------------------
  // Next-state and control decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    commit_go    = 1'b0;
    range_err_go = 1'b0;
    handshake    = 1'b0;

    case (state_q)
      IDLE: begin
        if (change) begin
          state_d = SETTLE;
          cnt_d   = RELOAD;
        end
      end

      SETTLE: begin
        if (change) begin
          cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (in_range) begin
          state_d   = COMMIT;
          commit_go = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d      = IDLE;
          range_err_go = 1'b1;
        end
      end

      COMMIT: begin
        // A change while the beat is in flight is remembered and re-settled
        // after the handshake; it never touches the beat itself.
        if (upd_ready) begin
          handshake = 1'b1;
          pending_d = 1'b0;
          if (pending_q || change) begin
            state_d = SETTLE;
            cnt_d   = RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else if (change) begin
          pending_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, settle counter and change tracking.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      prev_word <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      if (change) begin
        prev_word <= samp_word;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Update beat, error pulse and handshake counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_index <= 8'd0;
      upd_value <= 24'd0;
      err_range <= 1'b0;
      hs_count  <= 16'd0;
    end else begin
      err_range <= range_err_go;
      if (commit_go) begin
        upd_valid <= 1'b1;
        upd_index <= prev_word[31:24];
        upd_value <= prev_word[23:0];
      end else if (handshake) begin
        upd_valid <= 1'b0;
      end
      if (handshake) begin
        hs_count <= hs_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Parameter bank. Each slot is written only on the commit edge for its index.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (commit_go && (prev_word[31:24] == 8'(i))) begin
          bank_q[i*24 +: 24] <= prev_word[23:0];
        end
      end
    end
  end

  assign param_flat   = bank_q;
  assign update_count = hs_count;

endmodule

// File: tb/tb_param_word_capture.sv
// -----------------------------------------------------------------------------
// tb_param_word_capture
//
// Self-checking bench for param_word_capture with default parameters
// (NUM_PARAMS=16, STABLE_CYCLES=4). A cycle table covers basic commit, glitch
// filtering and the range error; hand sequences cover backpressure, reset
// during COMMIT and the handshake counter wrap.
// -----------------------------------------------------------------------------
module tb_param_word_capture;

  localparam int NP = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      in_word;
  logic             upd_ready;
  logic             upd_valid;
  logic [7:0]       upd_index;
  logic [23:0]      upd_value;
  logic [NP*24-1:0] param_flat;
  logic             err_range;
  logic [15:0]      update_count;

  int total = 0;
  int bad   = 0;

  param_word_capture #(
    .NUM_PARAMS(NP),
    .STABLE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_word(in_word),
    .upd_ready(upd_ready),
    .upd_valid(upd_valid),
    .upd_index(upd_index),
    .upd_value(upd_value),
    .param_flat(param_flat),
    .err_range(err_range),
    .update_count(update_count)
  );

  always #5 clk = ~clk;

  // Each row: inputs applied before an edge, outputs checked 1ns after it.
  typedef struct {
    logic [31:0] word;
    logic        exp_valid;
    logic [7:0]  exp_index;
    logic [23:0] exp_value;
    logic        exp_err;
    logic [15:0] exp_count;
    logic [23:0] exp_s1;
    logic [23:0] exp_s3;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic [31:0] w, input logic v, input logic [7:0] ix,
                              input logic [23:0] vl, input logic e, input logic [15:0] c,
                              input logic [23:0] s1, input logic [23:0] s3);
    vec_t r;
    r.word = w; r.exp_valid = v; r.exp_index = ix; r.exp_value = vl;
    r.exp_err = e; r.exp_count = c; r.exp_s1 = s1; r.exp_s3 = s3;
    return r;
  endfunction

  function automatic logic [23:0] slot(input int i);
    return param_flat[i*24 +: 24];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] w, input logic r);
    in_word   = w;
    upd_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [NP*24-1:0] act,
                             input logic [NP*24-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait for upd_valid; an expired budget shows up as a failed check.
  task automatic waitValid(input string name);
    int n = 0;
    while (upd_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, upd_valid, 1'b1);
  endtask

  task automatic doCommit(input logic [31:0] w, input string name);
    applyStimulus(w, 1'b1);
    waitValid(name);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NP*24-1:0] exp_flat;

    // -------------------------------------------------------------- reset state
    reset = 1'b1;
    applyStimulus(32'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst valid", upd_valid, 1'b0);
    checkOutput("rst index", upd_index, 8'd0);
    checkOutput("rst value", upd_value, 24'd0);
    checkOutput("rst err", err_range, 1'b0);
    checkOutput("rst count", update_count, 16'd0);
    checkOutput("rst flat", param_flat, '0);

    // Word 0 present at release must not commit, and ready in IDLE is ignored.
    #2 reset = 1'b0;
    applyStimulus(32'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("zero word %0d valid", i), upd_valid, 1'b0);
    end
    checkOutput("zero word count", update_count, 16'd0);

    // -------------------------------------------- table: commit, glitch, range
    vecs[0]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd0, 24'h0, 24'h0);
    vecs[1]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd0, 24'h0, 24'h0);
    vecs[2]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd0, 24'h0, 24'h0);
    vecs[3]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd0, 24'h0, 24'h0);
    vecs[4]  = mk(32'h0300ABCD, 1, 8'h03, 24'h00ABCD, 0, 16'd0, 24'h0, 24'h00ABCD);
    vecs[5]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[6]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[7]  = mk(32'h0300ABCD, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[8]  = mk(32'h01000005, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[9]  = mk(32'h01000005, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[10] = mk(32'h01000007, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[11] = mk(32'h01000007, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[12] = mk(32'h01000007, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[13] = mk(32'h01000007, 0, 8'h00, 24'h0, 0, 16'd1, 24'h0, 24'h00ABCD);
    vecs[14] = mk(32'h01000007, 1, 8'h01, 24'h000007, 0, 16'd1, 24'h000007, 24'h00ABCD);
    vecs[15] = mk(32'h01000007, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[16] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[17] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[18] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[19] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[20] = mk(32'h20123456, 0, 8'h00, 24'h0, 1, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[21] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);
    vecs[22] = mk(32'h20123456, 0, 8'h00, 24'h0, 0, 16'd2, 24'h000007, 24'h00ABCD);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].word, 1'b1);
      tick();
      checkOutput($sformatf("row%0d valid", i), upd_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("row%0d index", i), upd_index, vecs[i].exp_index);
        checkOutput($sformatf("row%0d value", i), upd_value, vecs[i].exp_value);
      end
      checkOutput($sformatf("row%0d err", i), err_range, vecs[i].exp_err);
      checkOutput($sformatf("row%0d count", i), update_count, vecs[i].exp_count);
      checkOutput($sformatf("row%0d slot1", i), slot(1), vecs[i].exp_s1);
      checkOutput($sformatf("row%0d slot3", i), slot(3), vecs[i].exp_s3);
    end

    exp_flat = '0;
    exp_flat[3*24 +: 24] = 24'h00ABCD;
    exp_flat[1*24 +: 24] = 24'h000007;
    checkOutput("range flat unchanged", param_flat, exp_flat);

    // ------------------------------------------------------------ backpressure
    applyStimulus(32'h05000111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("bp settle%0d valid", i), upd_valid, 1'b0);
    end
    tick();
    checkOutput("bp rise valid", upd_valid, 1'b1);
    for (int s = 1; s <= 10; s++) begin
      if (s == 3) applyStimulus(32'h02000001, 1'b0);
      tick();
      checkOutput($sformatf("bp stall%0d valid", s), upd_valid, 1'b1);
      checkOutput($sformatf("bp stall%0d index", s), upd_index, 8'h05);
      checkOutput($sformatf("bp stall%0d value", s), upd_value, 24'h000111);
    end
    applyStimulus(32'h02000001, 1'b1);
    tick();
    checkOutput("bp hs valid", upd_valid, 1'b0);
    checkOutput("bp hs count", update_count, 16'd3);
    checkOutput("bp slot5", slot(5), 24'h000111);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("bp resettle%0d valid", k), upd_valid, 1'b0);
    end
    tick();
    checkOutput("bp second valid", upd_valid, 1'b1);
    checkOutput("bp second index", upd_index, 8'h02);
    checkOutput("bp second value", upd_value, 24'h000001);
    tick();
    checkOutput("bp second hs valid", upd_valid, 1'b0);
    checkOutput("bp second count", update_count, 16'd4);
    checkOutput("bp slot2", slot(2), 24'h000001);

    // ------------------------------------------------------- reset mid-COMMIT
    applyStimulus(32'h04000444, 1'b0);
    waitValid("rmc reach commit");
    #2 reset = 1'b1;
    #1;
    checkOutput("rmc valid async", upd_valid, 1'b0);
    checkOutput("rmc flat", param_flat, '0);
    checkOutput("rmc count", update_count, 16'd0);
    applyStimulus(32'd0, 1'b1);
    tick();
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("rmc post%0d valid", i), upd_valid, 1'b0);
    end
    checkOutput("rmc post count", update_count, 16'd0);
    checkOutput("rmc post flat", param_flat, '0);

    // ---------------------------------------------------------- counter wrap
    // Preload the handshake counter near the top rather than run 65536 beats.
    force dut.hs_count = 16'hFFFE;
    #1;
    release dut.hs_count;
    checkOutput("wrap preload", update_count, 16'hFFFE);
    doCommit(32'h00000001, "wrap commit A");
    checkOutput("wrap count FFFF", update_count, 16'hFFFF);
    doCommit(32'h00000002, "wrap commit B");
    checkOutput("wrap count 0000", update_count, 16'h0000);
    checkOutput("wrap slot0", slot(0), 24'h000002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
